// File: rtl/mac_array_pkg.sv
// Shared definitions for the systolic MAC array: word widths, feeder FSM
// state encoding and a constant-width helper.
package mac_array_pkg;

    localparam int DEFAULT_WORD_SIZE  = 8;
    localparam int INTERNAL_WORD_SIZE = 2 * DEFAULT_WORD_SIZE;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } feeder_state_e;

    // Ceiling log2 usable in constant expressions; clog2(1) == 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/mac_skew_delay_line.sv
// Fixed-depth shift register carrying a data word plus a valid flag; one
// instance per array row sets that row's skew.
module mac_skew_delay_line #(
    parameter int DEPTH = 1,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o
);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the data stages are cleared too, not only the valid bits,
            // so a reset mid-frame never leaves stale words on left_out.
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= '0;
            end
            valid_q <= '0;
        end else begin
            data_q[0]  <= data_i;
            valid_q[0] <= valid_i;
            for (int i = 1; i < DEPTH; i++) begin
                data_q[i]  <= data_q[i-1];
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    assign data_o  = data_q[DEPTH-1];
    assign valid_o = valid_q[DEPTH-1];

endmodule

// File: rtl/mac_row_skew_feeder.sv
// Left-edge feeder: accepts un-skewed activation vectors and drives the MAC
// array rows with a diagonal skew, zero bubbles on stalls and a done pulse.
module mac_row_skew_feeder
    import mac_array_pkg::*;
#(
    parameter int ROWS      = 4,
    parameter int WORD_SIZE = DEFAULT_WORD_SIZE
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [ROWS*WORD_SIZE-1:0]   in_data,
    input  logic                        in_last,
    output logic [ROWS*2*WORD_SIZE-1:0] left_out,
    output logic [ROWS-1:0]             left_valid,
    output logic                        busy,
    output logic                        done
);

    localparam int IW = 2 * WORD_SIZE;
    localparam int CW = clog2(ROWS) + 1;

    feeder_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          accept;

    assign in_ready = (state_q == ST_IDLE) || (state_q == ST_STREAM);
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q != ST_IDLE);
    assign done     = (state_q == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns state_d and cnt_d,
        // which keeps this block free of inferred latches.
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE, ST_STREAM: begin
                if (accept && in_last) begin
                    if (ROWS == 1) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_DRAIN;
                        cnt_d   = CW'(ROWS - 1);
                    end
                end else if (accept) begin
                    state_d = ST_STREAM;
                end
            end
            ST_DRAIN: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Row r gets r+1 stages; non-accept cycles push a zero bubble into every row.
    for (genvar r = 0; r < ROWS; r++) begin : g_row
        logic [WORD_SIZE-1:0] word_in, word_out;
        logic                 valid_out;

        assign word_in = accept ? in_data[r*WORD_SIZE +: WORD_SIZE] : '0;

        mac_skew_delay_line #(
            .DEPTH (r + 1),
            .WIDTH (WORD_SIZE)
        ) u_line (
            .clk     (clk),
            .rst     (rst),
            .data_i  (word_in),
            .valid_i (accept),
            .data_o  (word_out),
            .valid_o (valid_out)
        );

        assign left_out[r*IW +: IW] = {{(IW - WORD_SIZE){1'b0}}, word_out};
        assign left_valid[r]        = valid_out;
    end

endmodule
